// File: rtl/hit_scorer_pkg.sv
// Shared constants, FSM state type and small arithmetic helpers for the whack-a-mole hit scorer.
package hit_scorer_pkg;

  localparam int NUM_HOLES  = 18;
  localparam int HIT_POINTS = 1;
  localparam int COMBO_STEP = 4;
  localparam int MAX_MULT   = 4;
  localparam int SCORE_MAX  = 9999;
  localparam int COMBO_MAX  = 99;

  localparam int SCORE_W = 14;
  localparam int COMBO_W = 7;
  localparam int MULT_W  = 3;
  localparam int NH_W    = 5;
  localparam int SUM_W   = SCORE_W + 1;
  localparam int CSUM_W  = COMBO_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  function automatic logic [NH_W-1:0] popcount(input logic [NUM_HOLES-1:0] v);
    logic [NH_W-1:0] n;
    n = NH_W'(0);
    for (int i = 0; i < NUM_HOLES; i++) begin
      n = n + NH_W'(v[i]);
    end
    return n;
  endfunction

  // Multiplier grows by one every COMBO_STEP consecutive hits, capped at MAX_MULT.
  function automatic logic [MULT_W-1:0] mult_of(input logic [COMBO_W-1:0] combo);
    logic [COMBO_W-1:0] steps;
    steps = combo / COMBO_W'(COMBO_STEP);
    if (steps >= COMBO_W'(MAX_MULT - 1)) begin
      return MULT_W'(MAX_MULT);
    end else begin
      return MULT_W'(steps) + MULT_W'(1);
    end
  endfunction

endpackage

// File: rtl/hit_scorer_switch_edge_sync.sv
// Two-flop synchroniser for the raw slide switches followed by a registered toggle detector.
// Reset preloads every stage with the live switch value so no whack is reported after reset.
module switch_edge_sync
  import hit_scorer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_HOLES-1:0] sw_raw,
  output logic [NUM_HOLES-1:0] whack
);

  logic [NUM_HOLES-1:0] sync1_r;
  logic [NUM_HOLES-1:0] sync2_r;
  logic [NUM_HOLES-1:0] prev_r;

  // Synchroniser chain, edge history and toggle pulse register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_r <= sw_raw;
      sync2_r <= sw_raw;
      prev_r  <= sw_raw;
      whack   <= {NUM_HOLES{1'b0}};
    end else begin
      sync1_r <= sw_raw;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      whack   <= sync2_r ^ prev_r;
    end
  end

endmodule

// File: rtl/hit_scorer.sv
// Judges synchronised switch toggles against the current round's moles and keeps score,
// combo count, multiplier, per-round hit mask and single-cycle hit/miss pulses.
module hit_scorer
  import hit_scorer_pkg::*;
(
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  input  logic                 game_active,
  input  logic                 mole_update,
  input  logic [NUM_HOLES-1:0] mole_positions,
  input  logic [NUM_HOLES-1:0] sw_raw,
  output logic [SCORE_W-1:0]   score,
  output logic [COMBO_W-1:0]   combo_count,
  output logic [MULT_W-1:0]    multiplier,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic [NUM_HOLES-1:0] hit_mask
);

  state_t               state_r;
  state_t               state_nxt_s;
  logic [NUM_HOLES-1:0] whack_s;
  logic [NUM_HOLES-1:0] mole_q_r;

  logic [NUM_HOLES-1:0] hits_s;
  logic [NUM_HOLES-1:0] missed_s;
  logic [NH_W-1:0]      nh_s;
  logic                 escape_s;
  logic                 break_s;
  logic [SUM_W-1:0]     add_s;
  logic [SUM_W-1:0]     sum_s;
  logic [SCORE_W-1:0]   score_sat_s;
  logic [CSUM_W-1:0]    combo_sum_s;
  logic [COMBO_W-1:0]   combo_new_s;
  logic                 start_s;
  logic                 play_s;

  logic [SCORE_W-1:0]   score_d_s;
  logic [COMBO_W-1:0]   combo_d_s;
  logic [MULT_W-1:0]    mult_d_s;
  logic                 hit_d_s;
  logic                 miss_d_s;
  logic [NUM_HOLES-1:0] mask_d_s;
  logic [NUM_HOLES-1:0] mole_d_s;

  switch_edge_sync u_sync (
    .clk     (CLOCK_50),
    .reset_n (reset_n),
    .sw_raw  (sw_raw),
    .whack   (whack_s)
  );

  // FSM state register.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (game_active) state_nxt_s = ST_PLAY;
        else             state_nxt_s = ST_IDLE;
      end
      ST_PLAY: begin
        if (!game_active) state_nxt_s = ST_IDLE;
        else              state_nxt_s = ST_PLAY;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Hit/miss/escape classification and saturating score/combo arithmetic.
  always_comb begin
    start_s  = (state_r == ST_IDLE) && game_active;
    play_s   = (state_r == ST_PLAY) && game_active;
    hits_s   = whack_s & mole_q_r & ~hit_mask;
    missed_s = whack_s & ~mole_q_r;
    nh_s     = popcount(hits_s);
    escape_s = mole_update && (|(mole_q_r & ~hit_mask & ~hits_s));
    break_s  = (|missed_s) || escape_s;

    add_s = SUM_W'(nh_s) * SUM_W'(HIT_POINTS) * SUM_W'(multiplier);
    sum_s = SUM_W'(score) + add_s;
    if (sum_s > SUM_W'(SCORE_MAX)) begin
      score_sat_s = SCORE_W'(SCORE_MAX);
    end else begin
      score_sat_s = sum_s[SCORE_W-1:0];
    end

    combo_sum_s = CSUM_W'(combo_count) + CSUM_W'(nh_s);
    if (break_s) begin
      combo_new_s = COMBO_W'(0);
    end else if (combo_sum_s > CSUM_W'(COMBO_MAX)) begin
      combo_new_s = COMBO_W'(COMBO_MAX);
    end else begin
      combo_new_s = combo_sum_s[COMBO_W-1:0];
    end
  end

  // Next values of all registered outputs and the latched mole mask.
  always_comb begin
    score_d_s = score;
    combo_d_s = combo_count;
    mult_d_s  = multiplier;
    hit_d_s   = 1'b0;
    miss_d_s  = 1'b0;
    mask_d_s  = hit_mask;
    mole_d_s  = mole_q_r;
    if (start_s) begin
      score_d_s = SCORE_W'(0);
      combo_d_s = COMBO_W'(0);
      mult_d_s  = MULT_W'(1);
      mask_d_s  = {NUM_HOLES{1'b0}};
      // A round starting on the very first cycle of a game must not be lost.
      if (mole_update) mole_d_s = mole_positions;
      else             mole_d_s = {NUM_HOLES{1'b0}};
    end else if (play_s) begin
      score_d_s = score_sat_s;
      combo_d_s = combo_new_s;
      mult_d_s  = mult_of(combo_new_s);
      hit_d_s   = (nh_s != NH_W'(0));
      miss_d_s  = break_s;
      if (mole_update) begin
        mole_d_s = mole_positions;
        mask_d_s = {NUM_HOLES{1'b0}};
      end else begin
        mask_d_s = hit_mask | hits_s;
      end
    end else begin
      if (mole_update) mole_d_s = mole_positions;
      else             mole_d_s = mole_q_r;
    end
  end

  // Output and round-state registers.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      score       <= SCORE_W'(0);
      combo_count <= COMBO_W'(0);
      multiplier  <= MULT_W'(1);
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      hit_mask    <= {NUM_HOLES{1'b0}};
      mole_q_r    <= {NUM_HOLES{1'b0}};
    end else begin
      score       <= score_d_s;
      combo_count <= combo_d_s;
      multiplier  <= mult_d_s;
      hit_pulse   <= hit_d_s;
      miss_pulse  <= miss_d_s;
      hit_mask    <= mask_d_s;
      mole_q_r    <= mole_d_s;
    end
  end

endmodule

// File: tb/tb_hit_scorer.sv
// Scoreboard bench for hit_scorer: stimulus pushes expected pulse-cycle snapshots, a monitor
// pops and compares them whenever hit_pulse or miss_pulse is high.
module tb_hit_scorer;
  import hit_scorer_pkg::*;

  typedef struct packed {
    logic [13:0] score;
    logic [6:0]  combo;
    logic [2:0]  mult;
    logic        hit;
    logic        miss;
    logic [17:0] mask;
  } obs_t;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  logic        game_active;
  logic        mole_update;
  logic [17:0] mole_positions;
  logic [17:0] sw_raw;
  logic [13:0] score;
  logic [6:0]  combo_count;
  logic [2:0]  multiplier;
  logic        hit_pulse;
  logic        miss_pulse;
  logic [17:0] hit_mask;

  obs_t  exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  obs_t  chk_exp;
  string chk_name;
  int    chk_seq = 0;
  int    seen_seq = 0;
  bit    end_req = 1'b0;
  int    m_score, m_combo, m_mult;

  localparam logic [17:0] MOLES3 = 18'h00007;

  hit_scorer dut (
    .CLOCK_50       (CLOCK_50),
    .reset_n        (reset_n),
    .game_active    (game_active),
    .mole_update    (mole_update),
    .mole_positions (mole_positions),
    .sw_raw         (sw_raw),
    .score          (score),
    .combo_count    (combo_count),
    .multiplier     (multiplier),
    .hit_pulse      (hit_pulse),
    .miss_pulse     (miss_pulse),
    .hit_mask       (hit_mask)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic obs_t mk(input int s, input int c, input int m, input logic h,
                              input logic mi, input logic [17:0] msk);
    obs_t o;
    o.score = 14'(s);
    o.combo = 7'(c);
    o.mult  = 3'(m);
    o.hit   = h;
    o.miss  = mi;
    o.mask  = msk;
    return o;
  endfunction

  function automatic logic [17:0] bit_of(input int i);
    logic [17:0] one;
    one = 18'd1;
    return one << i;
  endfunction

  task automatic report(input string name, input obs_t a, input obs_t e);
    $display("FAIL %s: got score=%0d combo=%0d mult=%0d hit=%0b miss=%0b mask=%05h, want score=%0d combo=%0d mult=%0d hit=%0b miss=%0b mask=%05h",
             name, a.score, a.combo, a.mult, a.hit, a.miss, a.mask,
             e.score, e.combo, e.mult, e.hit, e.miss, e.mask);
  endtask

  // Monitor: direct checks requested by stimulus, pulse-driven scoreboard, final drain check.
  initial begin
    obs_t act;
    obs_t e;
    forever begin
      @(negedge CLOCK_50);
      act = mk(int'(score), int'(combo_count), int'(multiplier), hit_pulse, miss_pulse, hit_mask);
      if (chk_seq != seen_seq) begin
        n_cmp++;
        if (act !== chk_exp) begin
          n_bad++;
          report(chk_name, act, chk_exp);
        end
        seen_seq = chk_seq;
      end
      if (reset_n === 1'b1 && (hit_pulse === 1'b1 || miss_pulse === 1'b1)) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_pulse: got hit=%0b miss=%0b score=%0d, want no pulse",
                   hit_pulse, miss_pulse, score);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_bad++;
            report("event", act, e);
          end
        end
      end
      if (end_req) begin
        n_cmp++;
        if (exp_q.size() != 0) begin
          n_bad++;
          $display("FAIL missing_events: got %0d outstanding, want 0", exp_q.size());
        end
        end_req = 1'b0;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic check(input string name, input obs_t e);
    chk_exp  = e;
    chk_name = name;
    chk_seq++;
    @(negedge CLOCK_50);
    #1;
  endtask

  task automatic new_round(input logic [17:0] mask);
    mole_positions = mask;
    mole_update    = 1'b1;
    step(1);
    mole_update    = 1'b0;
  endtask

  task automatic whack(input logic [17:0] mask);
    sw_raw = sw_raw ^ mask;
    step(4);
  endtask

  // Reference arithmetic for the long saturation run; pushes the expected pulse cycle.
  task automatic model(input int nh, input bit miss_any, input logic [17:0] mask_after);
    m_score = m_score + nh * m_mult;
    if (m_score > 9999) m_score = 9999;
    if (miss_any) m_combo = 0;
    else          m_combo = (m_combo + nh > 99) ? 99 : m_combo + nh;
    m_mult = 1 + m_combo / 4;
    if (m_mult > 4) m_mult = 4;
    exp_q.push_back(mk(m_score, m_combo, m_mult, nh > 0, miss_any, mask_after));
  endtask

  int sc_tab [16] = '{3, 4, 5, 6, 8, 10, 12, 14, 17, 20, 23, 26, 30, 34, 38, 42};
  int mu_tab [16] = '{1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 4, 4, 4, 4, 4};

  initial begin
    reset_n        = 1'b0;
    game_active    = 1'b0;
    mole_update    = 1'b0;
    mole_positions = 18'd0;
    sw_raw         = 18'd0;
    step(2);
    check("reset", mk(0, 0, 1, 1'b0, 1'b0, 18'd0));
    reset_n = 1'b1;
    whack(bit_of(3));
    step(2);
    check("idle_whack", mk(0, 0, 1, 1'b0, 1'b0, 18'd0));

    // First hit, then a repeat whack on the same mole is ignored.
    game_active = 1'b1;
    step(1);
    new_round(bit_of(4) | bit_of(9));
    exp_q.push_back(mk(1, 1, 1, 1'b1, 1'b0, bit_of(4)));
    whack(bit_of(4));
    whack(bit_of(4));
    check("rewhack", mk(1, 1, 1, 1'b0, 1'b0, bit_of(4)));

    // Hit and empty-hole miss on the same edge.
    exp_q.push_back(mk(2, 0, 1, 1'b1, 1'b1, bit_of(4) | bit_of(9)));
    whack(bit_of(9) | bit_of(5));

    // Sixteen clean hits: multiplier steps 1..4 and caps.
    for (int i = 0; i < 16; i++) begin
      new_round(bit_of(i));
      exp_q.push_back(mk(sc_tab[i], i + 1, mu_tab[i], 1'b1, 1'b0, bit_of(i)));
      whack(bit_of(i));
    end

    // Whack coinciding with round end is judged against the old round.
    new_round(bit_of(14));
    sw_raw = sw_raw ^ bit_of(14);
    step(3);
    exp_q.push_back(mk(46, 17, 4, 1'b1, 1'b0, 18'd0));
    new_round(bit_of(2));
    step(4);
    // Mole 2 escapes.
    exp_q.push_back(mk(46, 0, 1, 1'b0, 1'b1, 18'd0));
    new_round(bit_of(7));
    step(3);

    // Drive score to 9998 with multiplier 4, then saturate.
    exp_q.push_back(mk(47, 1, 1, 1'b1, 1'b0, bit_of(7)));
    whack(bit_of(7));
    m_score = 47;
    m_combo = 1;
    m_mult  = 1;
    while (m_score + 12 <= 9977) begin
      new_round(MOLES3);
      model(3, 1'b0, MOLES3);
      whack(MOLES3);
    end
    model(0, 1'b1, MOLES3);
    whack(bit_of(17));
    while (m_score < 9977) begin
      new_round(bit_of(0));
      model(1, 1'b1, bit_of(0));
      whack(bit_of(0) | bit_of(17));
    end
    repeat (4) begin
      new_round(MOLES3);
      model(3, 1'b0, MOLES3);
      whack(MOLES3);
    end
    check("pre_saturation", mk(9998, 12, 4, 1'b1, 1'b0, MOLES3));
    new_round(bit_of(5));
    exp_q.push_back(mk(9999, 13, 4, 1'b1, 1'b0, bit_of(5)));
    whack(bit_of(5));
    new_round(bit_of(6));
    exp_q.push_back(mk(9999, 14, 4, 1'b1, 1'b0, bit_of(6)));
    whack(bit_of(6));

    // Reset in the middle of a pending whack.
    new_round(bit_of(8));
    sw_raw = sw_raw ^ bit_of(8);
    step(2);
    reset_n = 1'b0;
    step(1);
    check("reset_mid_round", mk(0, 0, 1, 1'b0, 1'b0, 18'd0));
    step(1);
    reset_n = 1'b1;
    step(8);
    check("after_reset", mk(0, 0, 1, 1'b0, 1'b0, 18'd0));

    end_req = 1'b1;
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
